te_uop_queue: RTL and testbench

- Sits directly downstream of the ingress FSM: captures the single uop entry it emits per cycle (valid + mure_pkg::uop_entry_s) and presents entries to the trace encoder over a valid/ready handshake.
- The ingress FSM has no backpressure input, so this block absorbs encoder stalls, raises a stall request toward the core, and on overflow drops entries, counts the drops and tags the next accepted entry for resynchronisation.

---
 rtl/te_uop_queue.sv | 133 +++++++++++++
 tb/tb_te_uop_queue.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/te_uop_queue.sv
// te_uop_queue
//
// Elastic buffer between the ingress FSM and the trace encoder. The ingress
// FSM cannot be back-pressured, so this queue absorbs encoder stalls, asks
// the core to stall once occupancy gets high, and drops entries when
// completely full. Dropped entries are counted (saturating), flagged via a
// sticky overflow bit, and the next entry that is accepted is tagged with
// resync so the encoder can emit a resynchronisation packet.
//
// Ports:
//   clk_i       clock
//   rst_i       asynchronous reset, active-high
//   flush_i     synchronous clear of contents, overflow flag and drop count
//   valid_i     uop_i carries an entry this cycle
//   uop_i       entry from the ingress FSM
//   valid_o     head entry available
//   uop_o       head entry
//   resync_o    head entry is the first accepted after one or more drops
//   ready_i     encoder takes the head this cycle
//   stall_o     occupancy >= STALL_THRESH
//   level_o     occupancy, 0..DEPTH
//   overflow_o  sticky: an entry was dropped since reset/flush
//   drop_cnt_o  number of dropped entries, saturating
//
// UOP_W is the packed width of the uop entry struct; keeping it a parameter
// keeps this file free of a package dependency.

module te_uop_queue #(
    parameter int DEPTH        = 8,
    parameter int STALL_THRESH = 6,
    parameter int CNT_W        = 16,
    parameter int UOP_W        = 32
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       flush_i,
    input  logic                       valid_i,
    input  logic [UOP_W-1:0]           uop_i,
    output logic                       valid_o,
    output logic [UOP_W-1:0]           uop_o,
    output logic                       resync_o,
    input  logic                       ready_i,
    output logic                       stall_o,
    output logic [$clog2(DEPTH+1)-1:0] level_o,
    output logic                       overflow_o,
    output logic [CNT_W-1:0]           drop_cnt_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = $clog2(DEPTH + 1);

    // Each slot carries the entry plus its resync tag in the top bit.
    logic [UOP_W:0]     mem [DEPTH];
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic [LVL_W-1:0]   level;
    logic               overflow;
    logic [CNT_W-1:0]   drop_cnt;
    logic               resync_pend;

    logic               full;
    logic               pop;
    logic               push;
    logic               drop;
    logic [UOP_W:0]     head;

    assign full = (level == LVL_W'(DEPTH));
    assign pop  = valid_o && ready_i;
    // A full queue still accepts when the head leaves in the same cycle.
    assign push = valid_i && !flush_i && (!full || pop);
    assign drop = valid_i && !flush_i && full && !pop;

    assign head       = mem[rd_ptr];
    assign valid_o    = (level != '0);
    assign uop_o      = head[UOP_W-1:0];
    // Gated with valid_o so resync_o is 0 out of reset regardless of the
    // (unreset) storage contents.
    assign resync_o   = valid_o && head[UOP_W];
    assign stall_o    = (level >= LVL_W'(STALL_THRESH));
    assign level_o    = level;
    assign overflow_o = overflow;
    assign drop_cnt_o = drop_cnt;

    // Storage is not reset: slots are only observable while valid_o is set.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr] <= {resync_pend, uop_i};
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            level       <= '0;
            overflow    <= 1'b0;
            drop_cnt    <= '0;
            resync_pend <= 1'b0;
        end else if (flush_i) begin
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            level       <= '0;
            overflow    <= 1'b0;
            drop_cnt    <= '0;
            resync_pend <= 1'b0;
        end else begin
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end

            case ({push, pop})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase

            if (drop) begin
                overflow    <= 1'b1;
                resync_pend <= 1'b1;
                if (drop_cnt != {CNT_W{1'b1}}) begin
                    drop_cnt <= drop_cnt + CNT_W'(1);
                end
            end else if (push) begin
                // The entry written this cycle carried the pending tag.
                resync_pend <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_te_uop_queue.sv
module tb_te_uop_queue;

    localparam int DEPTH = 8;
    localparam int THR   = 6;
    localparam int CNT_W = 4;
    localparam int UOP_W = 16;

    logic             clk_i = 1'b0;
    logic             rst_i;
    logic             flush_i;
    logic             valid_i;
    logic [UOP_W-1:0] uop_i;
    logic             valid_o;
    logic [UOP_W-1:0] uop_o;
    logic             resync_o;
    logic             ready_i;
    logic             stall_o;
    logic [3:0]       level_o;
    logic             overflow_o;
    logic [CNT_W-1:0] drop_cnt_o;

    int checks = 0;
    int errors = 0;

    te_uop_queue #(
        .DEPTH(DEPTH), .STALL_THRESH(THR), .CNT_W(CNT_W), .UOP_W(UOP_W)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
        .valid_i(valid_i), .uop_i(uop_i),
        .valid_o(valid_o), .uop_o(uop_o), .resync_o(resync_o),
        .ready_i(ready_i), .stall_o(stall_o), .level_o(level_o),
        .overflow_o(overflow_o), .drop_cnt_o(drop_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        flush;
        logic        valid;
        logic        ready;
        logic [15:0] uop;
        logic        ev;
        logic [15:0] eu;
        logic        er;
        logic [3:0]  el;
        logic        es;
        logic        eo;
        logic [3:0]  ed;
    } vec_t;

    vec_t vq[$];

    function automatic void add(logic f, logic v, logic r, logic [15:0] u,
                                logic ev, logic [15:0] eu, logic er,
                                logic [3:0] el, logic es, logic eo, logic [3:0] ed);
        vec_t x;
        x.flush = f; x.valid = v; x.ready = r; x.uop = u;
        x.ev = ev; x.eu = eu; x.er = er; x.el = el;
        x.es = es; x.eo = eo; x.ed = ed;
        vq.push_back(x);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic ev, input logic [15:0] eu,
                           input logic er, input logic [3:0] el, input logic es,
                           input logic eo, input logic [3:0] ed);
        chk({tag, " valid"}, 32'(valid_o), 32'(ev));
        if (ev) chk({tag, " uop"}, 32'(uop_o), 32'(eu));
        chk({tag, " resync"}, 32'(resync_o), 32'(er));
        chk({tag, " level"}, 32'(level_o), 32'(el));
        chk({tag, " stall"}, 32'(stall_o), 32'(es));
        chk({tag, " overflow"}, 32'(overflow_o), 32'(eo));
        chk({tag, " drop_cnt"}, 32'(drop_cnt_o), 32'(ed));
    endtask

    task automatic drive(input logic f, input logic v, input logic r, input logic [15:0] u);
        flush_i = f; valid_i = v; ready_i = r; uop_i = u;
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        logic [15:0] drain [8];
        int lvl;

        // ---- vector table ----
        // basic push x3 then drain
        add(0,1,0,16'h0001, 1,16'h0001,0,4'd1,0,0,4'd0);
        add(0,1,0,16'h0002, 1,16'h0001,0,4'd2,0,0,4'd0);
        add(0,1,0,16'h0003, 1,16'h0001,0,4'd3,0,0,4'd0);
        add(0,0,1,16'h0000, 1,16'h0002,0,4'd2,0,0,4'd0);
        add(0,0,1,16'h0000, 1,16'h0003,0,4'd1,0,0,4'd0);
        add(0,0,1,16'h0000, 0,16'h0000,0,4'd0,0,0,4'd0);
        add(0,0,1,16'h0000, 0,16'h0000,0,4'd0,0,0,4'd0);
        // A..J with encoder stalled: two drops
        for (int k = 1; k <= 10; k++) begin
            lvl = (k > 8) ? 8 : k;
            add(0,1,0,16'(16'hA0 + k - 1), 1,16'hA0,0,4'(lvl),
                (lvl >= 6), (k > 8), 4'((k > 8) ? k - 8 : 0));
        end
        // K arrives while full and the head pops: accepted, tagged resync
        add(0,1,1,16'h00AB, 1,16'h00A1,0,4'd8,1,1,4'd2);
        drain = '{16'hA1,16'hA2,16'hA3,16'hA4,16'hA5,16'hA6,16'hA7,16'hAB};
        for (int j = 1; j <= 8; j++) begin
            lvl = 8 - j;
            add(0,0,1,16'h0000, (lvl != 0), (j < 8) ? drain[j] : 16'h0,
                (j == 7), 4'(lvl), (lvl >= 6), 1, 4'd2);
        end

        // ---- reset ----
        drive(0,0,0,16'h0);
        rst_i = 1'b1;
        tick();
        tick();
        chk_all("reset", 0,16'h0,0,4'd0,0,0,4'd0);
        rst_i = 1'b0;

        for (int i = 0; i < vq.size(); i++) begin
            drive(vq[i].flush, vq[i].valid, vq[i].ready, vq[i].uop);
            tick();
            chk_all($sformatf("vec%0d", i), vq[i].ev, vq[i].eu, vq[i].er,
                    vq[i].el, vq[i].es, vq[i].eo, vq[i].ed);
        end

        // ---- full queue, simultaneous push and pop ----
        for (int i = 0; i < 8; i++) begin
            drive(0,1,0,16'(16'hC0 + i));
            tick();
        end
        chk_all("fill_c", 1,16'hC0,0,4'd8,1,1,4'd2);
        for (int i = 0; i < 4; i++) begin
            drive(0,1,1,16'(16'hC8 + i));
            tick();
            chk_all($sformatf("pushpop%0d", i), 1,16'(16'hC1 + i),0,4'd8,1,1,4'd2);
        end
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("order%0d", i), 32'(uop_o), 32'(16'hC4 + i));
            drive(0,0,1,16'h0);
            tick();
        end
        chk("drained_c valid", 32'(valid_o), 32'd0);

        // ---- drop counter saturation ----
        for (int i = 0; i < 8; i++) begin
            drive(0,1,0,16'(16'hD0 + i));
            tick();
        end
        for (int n = 1; n <= 16; n++) begin
            drive(0,1,0,16'(16'hE0 + n));
            tick();
            chk($sformatf("sat%0d", n), 32'(drop_cnt_o), (2 + n > 15) ? 32'd15 : 32'(2 + n));
        end
        chk("sat level", 32'(level_o), 32'd8);

        // ---- flush with simultaneous valid at level 5 ----
        for (int i = 0; i < 3; i++) begin
            drive(0,0,1,16'h0);
            tick();
        end
        chk_all("pre_flush", 1,16'hD3,0,4'd5,0,1,4'd15);
        drive(1,1,1,16'h00EE);
        tick();
        chk_all("flush", 0,16'h0,0,4'd0,0,0,4'd0);
        drive(0,1,0,16'h00F1);
        tick();
        chk_all("post_flush", 1,16'h00F1,0,4'd1,0,0,4'd0);
        drive(0,0,1,16'h0);
        tick();
        chk("flush_gone valid", 32'(valid_o), 32'd0);

        // ---- async reset mid-stream, with a resync pending ----
        for (int i = 0; i < 8; i++) begin
            drive(0,1,0,16'(16'h30 + i));
            tick();
        end
        drive(0,1,0,16'h003F);
        tick();
        for (int i = 0; i < 4; i++) begin
            drive(0,0,1,16'h0);
            tick();
        end
        chk_all("pre_rst", 1,16'h0034,0,4'd4,0,1,4'd1);
        drive(0,0,0,16'h0);
        #3;
        rst_i = 1'b1;
        #1;
        chk_all("async_rst", 0,16'h0,0,4'd0,0,0,4'd0);
        @(posedge clk_i);
        #2;
        rst_i = 1'b0;
        drive(0,1,0,16'h0077);
        tick();
        chk_all("post_rst", 1,16'h0077,0,4'd1,0,0,4'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
